// File: rtl/shift_seq_ctrl_if.sv
// Bundle of control, shift-register and status signals for shift_seq_ctrl.
// Optional RxData member exists only when SHIFT_SEQ_CAPTURE_EN is defined.
interface shift_seq_ctrl_if;
  // Handshake: a transfer is accepted on the rising edge where Start=1,
  // Ready=1 and Abort=0; Start is ignored whenever Ready=0 (no queuing).
  logic        Start;
  logic        Ready;
  logic [15:0] TxData;
  logic [3:0]  Len;
  logic        Dir;
  logic        SerIn;
  logic        Abort;
  logic        Load;
  logic        Left;
  logic        ShiftEn;
  logic        Din;
  logic [15:0] A;
  logic        Dout;
  logic        Busy;
  logic        Done;
  logic [4:0]  BitCnt;
  logic [2:0]  State;
`ifdef SHIFT_SEQ_CAPTURE_EN
  logic [15:0] RxData;
`endif

  modport master (
    output Start, TxData, Len, Dir, SerIn, Abort, Dout,
    input
`ifdef SHIFT_SEQ_CAPTURE_EN
          RxData,
`endif
          Ready, Load, Left, ShiftEn, Din, A, Busy, Done, BitCnt, State
  );

  modport slave (
    input  Start, TxData, Len, Dir, SerIn, Abort, Dout,
    output
`ifdef SHIFT_SEQ_CAPTURE_EN
           RxData,
`endif
           Ready, Load, Left, ShiftEn, Din, A, Busy, Done, BitCnt, State
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Sequencer for an external shift register: IDLE -> LOAD -> SHIFT(N) -> DRAIN -> DONE.
// Define SHIFT_SEQ_CAPTURE_EN to add serial capture of Dout into RxData.
module shift_seq_ctrl (
  input  logic           Clk,
  input  logic           Rst_n,
  shift_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] data_q, data_d;
  logic [3:0]  len_q, len_d;
  logic        dir_q, dir_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  n_last;
  logic        accept;
  logic        load;
  logic        left;
  logic        shift_en;
  logic        done;

  // Len=0 encodes 16 shifts, so the last SHIFT cycle sees cnt_q == 15.
  assign n_last = (len_q == 4'd0) ? 5'd15 : ({1'b0, len_q} - 5'd1);
  assign accept = (state_q == IDLE) && bus.Start && !bus.Abort;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      data_q  <= 16'd0;
      len_q   <= 4'd0;
      dir_q   <= 1'b0;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      len_q   <= len_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    len_d    = len_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    left     = 1'b0;
    shift_en = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = LOAD;
          data_d  = bus.TxData;
          len_d   = bus.Len;
          dir_d   = bus.Dir;
          cnt_d   = 5'd0;
        end
      end
      LOAD: begin
        load    = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        shift_en = 1'b1;
        left     = dir_q;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == n_last) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        done    = !bus.Abort;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Abort wins in every active state and freezes the shift count.
    if (state_q != IDLE && bus.Abort) begin
      state_d = IDLE;
      cnt_d   = cnt_q;
    end
  end

  assign bus.Load    = load;
  assign bus.Left    = left;
  assign bus.ShiftEn = shift_en;
  assign bus.Done    = done;
  assign bus.Din     = bus.SerIn;
  assign bus.A       = data_q;
  assign bus.BitCnt  = cnt_q;
  assign bus.Busy    = (state_q != IDLE);
  assign bus.Ready   = (state_q == IDLE);
  assign bus.State   = state_q;

`ifdef SHIFT_SEQ_CAPTURE_EN
  logic [15:0] rx_q;

  // Dout lags the shift by one cycle, so capture skips the first SHIFT
  // cycle and picks up the final bit in DRAIN.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rx_q <= 16'd0;
    end else if (accept) begin
      rx_q <= 16'd0;
    end else if ((state_q == SHIFT && cnt_q != 5'd0) || state_q == DRAIN) begin
      rx_q <= dir_q ? {rx_q[14:0], bus.Dout} : {bus.Dout, rx_q[15:1]};
    end
  end

  assign bus.RxData = rx_q;
`else
  logic unused_dout;
  assign unused_dout = bus.Dout;
`endif

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 SHALL have port Clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port Rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port Start  in  1  transfer request, sampled only while Ready=1.
REQ-004 SHALL have port Ready  out  1  high only in IDLE.
REQ-005 SHALL have port TxData  in  16  parallel word to transmit, latched on accept.
REQ-006 SHALL have port Len  in  4  bit count, latched on accept; 0 encodes 16.
REQ-007 SHALL have port Dir  in  1  1 = MSB-first (left), 0 = LSB-first (right), latched on accept.
REQ-008 SHALL have port SerIn  in  1  fill bit, passed straight to the shift register Din.
REQ-009 SHALL have port Abort  in  1  cancel the current transfer.
REQ-010 SHALL have ports Load, Left, ShiftEn, Din (out, 1 each) and A (out, 16), driving the shift register.
REQ-011 SHALL have port Dout  in  1  registered serial output of the shift register.
REQ-012 SHALL have ports Busy (out 1), Done (out 1, one-cycle pulse) and BitCnt (out 5, shifts completed).

Function
REQ-013 SHALL implement the states IDLE, LOAD, SHIFT, DRAIN and DONE.
REQ-014 SHALL accept on the edge where Start=1 and state=IDLE, latch TxData, Len and Dir, and move to LOAD.
REQ-015 LOAD SHALL last one cycle with Load=1, A=latched TxData and ShiftEn=0; A SHALL hold the latched value in all states.
REQ-016 SHIFT SHALL last exactly N cycles (N=Len, or 16 when Len=0) with ShiftEn=1, Load=0, Left=latched Dir, and BitCnt incrementing by 1 per cycle from 0 to N.
REQ-017 DRAIN SHALL last one cycle with ShiftEn=0, then DONE SHALL last one cycle with Done=1, then the block SHALL return to IDLE.
REQ-018 Done SHALL therefore assert in cycle N+3 after the accept edge (LOAD = cycle 1).
REQ-019 Busy SHALL equal 1 in every state except IDLE, and Ready SHALL equal NOT Busy.
REQ-020 Left and Load SHALL be 0 in IDLE, DRAIN and DONE.
REQ-021 Din SHALL equal SerIn combinationally in all states.
REQ-022 Start SHALL be ignored when state is not IDLE; no queuing.
REQ-023 Abort=1 in any non-IDLE state SHALL force IDLE on the next edge with no Done pulse; BitCnt SHALL hold its last value.
REQ-024 Abort SHALL have priority over Start and SHALL be ignored in IDLE.
REQ-025 Start and Abort both high in IDLE SHALL not accept a transfer.
REQ-026 BitCnt SHALL clear to 0 on accept, SHALL be 5 bits wide so that 16 is representable, and SHALL never wrap.

Reset
REQ-027 Rst_n=0 SHALL immediately force IDLE regardless of Clk.
REQ-028 Reset SHALL force Load=0, Left=0, ShiftEn=0, Busy=0, Done=0, BitCnt=0, A=0 and the latched Len/Dir=0, with Ready=1.
REQ-029 Reset asserted mid-transfer SHALL abandon the transfer with no Done pulse.

Configuration
REQ-030 With macro SHIFT_SEQ_CAPTURE_EN defined, the block SHALL add output RxData (out 16, reset 0) that captures Dout in each SHIFT cycle except the first, and in DRAIN (N captures total).
REQ-031 Capture SHALL be RxData <= {RxData[14:0], Dout} when Dir=1 and RxData <= {Dout, RxData[15:1]} when Dir=0.
REQ-032 RxData SHALL be stable from DONE until the next accept, and SHALL clear to 0 on accept.
REQ-033 Without SHIFT_SEQ_CAPTURE_EN, RxData and its capture logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-034 Accept TxData=16'hA5C3, Len=0, Dir=1 -> Load for 1 cycle, ShiftEn for 16 cycles, Done in cycle 19, BitCnt=16; RxData=16'hA5C3 (CAPTURE_EN).
REQ-035 Accept TxData=16'h00F1, Len=4, Dir=0 -> ShiftEn for 4 cycles, Done in cycle 7; RxData[15:12]=4'h1 (CAPTURE_EN).
REQ-036 Abort in the 3rd SHIFT cycle of a Len=8 transfer -> IDLE next edge, no Done, Ready=1, BitCnt=2.
REQ-037 Start pulsed during SHIFT -> ignored, exactly one Done; Start and Abort together in IDLE -> no accept.
REQ-038 Rst_n low between clock edges during SHIFT -> all outputs at reset values immediately, no Done after release.
REQ-039 Back-to-back transfers with Start held high -> second accept in the cycle after DONE, with BitCnt restarting at 0.
